result_serializer: RTL and testbench
====================================

RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 Parameter HEADER_EN, default 1; 1 sends a header byte before the result bytes, 0 omits it.
REQ-002 Parameter HEADER_BYTE, default 8'hA5; the value of the header byte.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 done  input  1  level from the multiplier; goes high once results are valid and stays high.
REQ-006 c0..c8  input  16 each  result matrix elements, row-major.
REQ-007 tx_data  output  8  byte presented to the downstream byte sink (UART TX).
REQ-008 tx_valid  output  1  tx_data holds a byte to transfer.
REQ-009 tx_ready  input  1  the sink accepts tx_data this cycle.
REQ-010 busy  output  1  high from capture until the last byte is accepted.
REQ-011 frame_sent  output  1  one-cycle pulse after the final byte of a frame is accepted.

Function
REQ-012 A byte transfer occurs on a rising clk edge where tx_valid=1 and tx_ready=1.
REQ-013 The FSM has states IDLE, SEND and FINISH; reset enters IDLE.
REQ-014 A done rising edge is done=1 with the registered previous done_d=0; done_d resets to 0, so done already high at reset release counts as a rising edge.
REQ-015 IDLE: on a done rising edge, capture c0..c8 into an internal 9x16 buffer, clear the byte index, set busy=1 and go to SEND.
REQ-016 tx_valid asserts in the cycle after the capture edge (latency 1).
REQ-017 Frame order: optional header, then c0[15:8], c0[7:0], c1[15:8], ..., c8[7:0].
REQ-018 Frame length is 19 bytes with HEADER_EN=1 and 18 bytes with HEADER_EN=0.
REQ-019 tx_data is driven from a registered byte index into the captured buffer; it never reads the live c inputs after capture.
REQ-020 While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable (no retraction, no change).
REQ-021 After each non-final transfer, the next byte is presented in the following cycle with tx_valid kept high.
REQ-022 With tx_ready held high, the full frame completes in frame-length consecutive cycles.
REQ-023 On transfer of the final byte, go to FINISH; tx_valid=0 and busy=0 from the next cycle.
REQ-024 FINISH: frame_sent=1 for exactly one cycle, then return to IDLE.
REQ-025 Done rising edges seen in SEND or FINISH are ignored; a new frame needs done to fall and rise again while in IDLE.
REQ-026 c inputs changing after capture do not alter the frame in flight.
REQ-027 tx_ready high while tx_valid=0 has no effect.
REQ-028 The byte index is 5 bits and never exceeds frame length minus 1; no wrap-around occurs inside a frame.

Reset
REQ-029 rst=1 immediately, without a clock, forces: tx_valid=0, tx_data=8'h00, busy=0, frame_sent=0, state IDLE, byte index 0, done_d=0, buffer cleared to 0.
REQ-030 Reset asserted mid-frame aborts the frame; no partial frame resumes after release.
REQ-031 After rst deasserts with done still high, a new full frame starts (per REQ-014).

Structure
REQ-032 State encodings, frame-length constants and the default header value belong in the shared project package used by the matrix blocks.
REQ-033 The done edge detector is a natural sub-module, edge_detect_rise (clk, rst, in, rise); everything else stays in result_serializer.

Verification
REQ-034 c0=16'h1234, c8=16'hBEEF, others 0, done rises, tx_ready=1: bytes A5,12,34,00,...,BE,EF over 19 consecutive cycles; frame_sent one cycle later.
REQ-035 Same stimulus with tx_ready toggling 1/0 every cycle: same 19-byte sequence; tx_data stable during every ready-low cycle.
REQ-036 HEADER_EN=0, all c=16'hFFFF: exactly 18 bytes of FF; no A5 appears.
REQ-037 done held high after the frame and c changed to 16'h0001: no second frame; after done drops and rises again, a new frame carries 00,01 pairs.
REQ-038 rst pulsed after the 7th byte is accepted: tx_valid=0 asynchronously; after release with done high, a complete fresh 19-byte frame starts with A5.
REQ-039 done held high through reset release: first tx_valid appears 1 cycle after the first post-reset edge that samples done.

Source files
------------

// File: rtl/result_serializer_pkg.sv
// rtl/result_serializer_pkg.sv - shared serializer states, frame sizes and header default
package result_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_FINISH = 2'd2
    } ser_state_e;

    localparam int         N_ELEMS         = 9;
    localparam int         N_DATA_BYTES    = 2 * N_ELEMS;
    localparam int         FRAME_LEN_HDR   = N_DATA_BYTES + 1;
    localparam int         FRAME_LEN_NOHDR = N_DATA_BYTES;
    localparam int         IDX_W           = 5;
    localparam logic [7:0] DEFAULT_HEADER  = 8'hA5;

    function automatic logic [IDX_W-1:0] last_index(input bit header_en);
        return header_en ? IDX_W'(FRAME_LEN_HDR - 1) : IDX_W'(FRAME_LEN_NOHDR - 1);
    endfunction

endpackage

// File: rtl/result_serializer_edge_detect_rise.sv
// rtl/result_serializer_edge_detect_rise.sv - rising-edge detector with registered previous level
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic in_q;

    // Previous level resets low so a level already high at reset release reads as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - captures a 3x3 result matrix and streams it as a byte frame
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done,
    input  logic [15:0] c0,
    input  logic [15:0] c1,
    input  logic [15:0] c2,
    input  logic [15:0] c3,
    input  logic [15:0] c4,
    input  logic [15:0] c5,
    input  logic [15:0] c6,
    input  logic [15:0] c7,
    input  logic [15:0] c8,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_sent
);

    localparam logic [IDX_W-1:0] LAST_IDX = last_index(HEADER_EN);
    localparam logic [IDX_W-1:0] HDR_OFS  = {{(IDX_W-1){1'b0}}, HEADER_EN};

    ser_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       bytes_q [N_DATA_BYTES];
    logic [7:0]       bytes_d [N_DATA_BYTES];
    logic             done_rise;
    logic             capture;
    logic             xfer;
    logic             last_xfer;
    logic [IDX_W-1:0] data_idx;

    edge_detect_rise u_done_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (done),
        .rise (done_rise)
    );

    assign capture   = (state_q == ST_IDLE) && done_rise;
    assign xfer      = (state_q == ST_SEND) && tx_ready;
    assign last_xfer = xfer && (idx_q == LAST_IDX);
    assign data_idx  = idx_q - HDR_OFS;

    // Buffer is stored as big-endian bytes so the byte index maps straight onto it.
    always_comb begin
        bytes_d = bytes_q;
        if (capture) begin
            bytes_d = '{c0[15:8], c0[7:0], c1[15:8], c1[7:0], c2[15:8], c2[7:0],
                        c3[15:8], c3[7:0], c4[15:8], c4[7:0], c5[15:8], c5[7:0],
                        c6[15:8], c6[7:0], c7[15:8], c7[7:0], c8[15:8], c8[7:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            bytes_q <= '{default: 8'h00};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bytes_q <= bytes_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                if (last_xfer) begin
                    state_d = ST_FINISH;
                    idx_d   = '0;
                end else if (xfer) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid   = 1'b0;
        busy       = 1'b0;
        frame_sent = 1'b0;
        tx_data    = 8'h00;
        case (state_q)
            ST_SEND: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = (HEADER_EN && (idx_q == '0)) ? HEADER_BYTE : bytes_q[data_idx];
            end
            ST_FINISH: frame_sent = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - directed and randomized checks of result_serializer
module tb_result_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done0 = 1'b0;
    logic        done1 = 1'b0;
    logic        tx_ready = 1'b0;
    logic [15:0] c [9];
    logic [7:0]  tx_data0, tx_data1;
    logic        tx_valid0, tx_valid1, busy0, busy1, fs0, fs1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] c_model [9];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];

    always #5 clk = ~clk;

    result_serializer #(.HEADER_EN(1'b1), .HEADER_BYTE(8'hA5)) dut_hdr (
        .clk(clk), .rst(rst), .done(done0),
        .c0(c[0]), .c1(c[1]), .c2(c[2]), .c3(c[3]), .c4(c[4]),
        .c5(c[5]), .c6(c[6]), .c7(c[7]), .c8(c[8]),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
        .busy(busy0), .frame_sent(fs0)
    );

    result_serializer #(.HEADER_EN(1'b0), .HEADER_BYTE(8'hA5)) dut_nohdr (
        .clk(clk), .rst(rst), .done(done1),
        .c0(c[0]), .c1(c[1]), .c2(c[2]), .c3(c[3]), .c4(c[4]),
        .c5(c[5]), .c6(c[6]), .c7(c[7]), .c8(c[8]),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
        .busy(busy1), .frame_sent(fs1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic       v_of(input bit w);  return w ? tx_valid1 : tx_valid0; endfunction
    function automatic logic [7:0] d_of(input bit w);  return w ? tx_data1  : tx_data0;  endfunction
    function automatic logic       b_of(input bit w);  return w ? busy1     : busy0;     endfunction
    function automatic logic       fs_of(input bit w); return w ? fs1       : fs0;       endfunction

    // Expected frame straight from the frame-order rule: optional header, then each element high byte first.
    function automatic void build_exp(input bit hdr);
        exp_q.delete();
        if (hdr) exp_q.push_back(8'hA5);
        for (int e = 0; e < 9; e++) begin
            exp_q.push_back(8'(c_model[e] >> 8));
            exp_q.push_back(8'(c_model[e] & 16'h00FF));
        end
    endfunction

    task automatic randomize_c();
        for (int e = 0; e < 9; e++) c[e] = 16'($urandom);
    endtask

    task automatic start_frame(input bit w, input bit scramble);
        tx_ready = 1'b0;
        c_model  = c;
        build_exp(!w);
        if (w) done1 = 1'b1; else done0 = 1'b1;
        @(negedge clk);
        check("latency_valid", v_of(w), 1'b1);
        if (scramble) randomize_c();
    endtask

    task automatic run_frame(input bit w, input int mode);
        int         cyc = 0;
        int         first = -1;
        int         lastc = -1;
        bit         pv = 0, pr = 0, fin = 0;
        logic [7:0] pd = 8'h00;
        logic       vv, r;
        logic [7:0] dd;
        got_q.delete();
        while (!fin && cyc < 400) begin
            vv = v_of(w);
            dd = d_of(w);
            if (pv && !pr) begin
                check("hold_valid", vv, 1'b1);
                check("hold_data", dd, pd);
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            tx_ready = r;
            if (vv && first < 0) first = cyc;
            if (vv && r) begin
                got_q.push_back(dd);
                if (got_q.size() == exp_q.size()) begin
                    lastc = cyc;
                    fin   = 1;
                end
            end
            pv = vv; pr = r; pd = dd;
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b0;
        check("frame_complete", fin, 1'b1);
        check("frame_len", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
        if (mode == 0) check("consecutive_cycles", lastc - first + 1, exp_q.size());
        check("post_valid_low", v_of(w), 1'b0);
        check("post_busy_low", b_of(w), 1'b0);
        check("frame_sent_pulse", fs_of(w), 1'b1);
        @(negedge clk);
        check("frame_sent_one_cycle", fs_of(w), 1'b0);
    endtask

    initial begin
        int n;
        for (int e = 0; e < 9; e++) c[e] = 16'h0000;
        #2;
        check("rst_valid0", tx_valid0, 1'b0);
        check("rst_data0", tx_data0, 8'h00);
        check("rst_busy0", busy0, 1'b0);
        check("rst_fs0", fs0, 1'b0);
        check("rst_valid1", tx_valid1, 1'b0);
        check("rst_data1", tx_data1, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        c[0] = 16'h1234; c[8] = 16'hBEEF;
        start_frame(0, 1);
        check("first_byte_header", tx_data0, 8'hA5);
        run_frame(0, 0);

        done0 = 1'b0;
        @(negedge clk);
        for (int e = 0; e < 9; e++) c[e] = 16'h0000;
        c[0] = 16'h1234; c[8] = 16'hBEEF;
        start_frame(0, 1);
        run_frame(0, 1);

        for (int e = 0; e < 9; e++) c[e] = 16'h0001;
        n = 0;
        tx_ready = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (tx_valid0 || busy0) n++;
        end
        check("no_retrigger_while_high", n, 0);
        done0 = 1'b0;
        @(negedge clk);
        start_frame(0, 0);
        run_frame(0, 2);

        for (int k = 0; k < 4; k++) begin
            done0 = 1'b0;
            @(negedge clk);
            randomize_c();
            start_frame(0, 1);
            run_frame(0, k % 3);
        end

        for (int e = 0; e < 9; e++) c[e] = 16'hFFFF;
        start_frame(1, 0);
        run_frame(1, 0);
        n = 0;
        foreach (got_q[i]) if (got_q[i] == 8'hA5) n++;
        check("nohdr_no_a5", n, 0);
        done1 = 1'b0;
        @(negedge clk);
        randomize_c();
        start_frame(1, 1);
        run_frame(1, 2);

        done0 = 1'b0;
        @(negedge clk);
        randomize_c();
        start_frame(0, 1);
        tx_ready = 1'b1;
        repeat (7) @(negedge clk);
        check("pre_abort_data", tx_data0, exp_q[7]);
        rst = 1'b1;
        #1;
        check("abort_valid", tx_valid0, 1'b0);
        check("abort_busy", busy0, 1'b0);
        check("abort_data", tx_data0, 8'h00);
        check("abort_fs", fs0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
        check("in_reset_valid", tx_valid0, 1'b0);
        rst = 1'b0;
        c_model = c;
        build_exp(1'b1);
        check("release_valid_low", tx_valid0, 1'b0);
        @(negedge clk);
        check("post_reset_latency", tx_valid0, 1'b1);
        check("post_reset_header", tx_data0, 8'hA5);
        run_frame(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
